id_stage_sb: RTL and testbench

//  Parametrised decode stage: register file with write-back port, decode and

---
 rtl/id_stage_sb.sv | 160 ++++++++++++++++
 tb/tb_id_stage_sb.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_sb.sv
// Decode stage: register file with write-back port, field decode, immediate
// extension and a per-register pending-write scoreboard that holds off RAW/WAW issue.
module id_stage_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int PEND_W = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [31:0]     INS,
  input  logic            WB_EN,
  input  logic [AW-1:0]   WB_ADR,
  input  logic [XLEN-1:0] WB_DATA,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RDATA1,
  output logic [XLEN-1:0] RDATA2,
  output logic [XLEN-1:0] ED32,
  output logic [AW-1:0]   DST,
  output logic [5:0]      OP,
  output logic [5:0]      FUNCT,
  output logic [4:0]      SHAMT,
  output logic            HAZARD
);

  logic [XLEN-1:0]   reg_q [NREG];
  logic [XLEN-1:0]   reg_d [NREG];
  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rdata1_q, rdata1_d, rdata2_q, rdata2_d, ed32_q, ed32_d;
  logic [AW-1:0]   dst_q, dst_d;
  logic [5:0]      op_q, op_d, funct_q, funct_d;
  logic [4:0]      shamt_q, shamt_d;

  logic [5:0]      op_w;
  logic [AW-1:0]   rs_a, rt_a, dst_w;
  logic            use_rs, use_rt, rs_busy, rt_busy, dst_full, hazard_w, issue;
  logic [XLEN-1:0] ed_w, rd1_w, rd2_w;

  always_comb begin
    op_w   = INS[31:26];
    rs_a   = AW'(INS[25:21]);
    rt_a   = AW'(INS[20:16]);
    use_rs = !(op_w == 6'h03 || op_w == 6'h02);
    use_rt = (op_w == 6'h00) || (op_w == 6'h04) || (op_w == 6'h05) || (op_w == 6'h2B);

    case (op_w)
      6'h03:                   dst_w = AW'(31);
      6'h00:                   dst_w = AW'(INS[15:11]);
      6'h04, 6'h05, 6'h2B:     dst_w = '0;
      default:                 dst_w = rt_a;
    endcase

    if (op_w == 6'h0C || op_w == 6'h0D || op_w == 6'h0E)
      ed_w = {{(XLEN-16){1'b0}}, INS[15:0]};
    else
      ed_w = {{(XLEN-16){INS[15]}}, INS[15:0]};

    // A last outstanding write landing this cycle is forwardable, so it does not stall.
    rs_busy  = use_rs && (rs_a != '0) && (pend_q[rs_a] != '0) &&
               !((BYPASS != 0) && WB_EN && (WB_ADR == rs_a) && (pend_q[rs_a] == PEND_W'(1)));
    rt_busy  = use_rt && (rt_a != '0) && (pend_q[rt_a] != '0) &&
               !((BYPASS != 0) && WB_EN && (WB_ADR == rt_a) && (pend_q[rt_a] == PEND_W'(1)));
    dst_full = (dst_w != '0) && (pend_q[dst_w] == '1);
    hazard_w = rs_busy || rt_busy || dst_full;

    if (rs_a == '0)                                          rd1_w = '0;
    else if ((BYPASS != 0) && WB_EN && (WB_ADR == rs_a))      rd1_w = WB_DATA;
    else                                                     rd1_w = reg_q[rs_a];

    if (rt_a == '0)                                          rd2_w = '0;
    else if ((BYPASS != 0) && WB_EN && (WB_ADR == rt_a))      rd2_w = WB_DATA;
    else                                                     rd2_w = reg_q[rt_a];
  end

  assign IN_READY = RST && !hazard_w && (!out_valid_q || OUT_READY);
  assign issue    = IN_VALID && IN_READY;
  assign HAZARD   = hazard_w;

  always_comb begin
    reg_d = reg_q;
    if (WB_EN && (WB_ADR != '0))
      reg_d[WB_ADR] = WB_DATA;

    for (int r = 0; r < NREG; r++) begin
      pend_d[r] = pend_q[r];
      if (issue && (dst_w == AW'(r)) && (dst_w != '0) && !(WB_EN && (WB_ADR == AW'(r))))
        pend_d[r] = pend_q[r] + PEND_W'(1);
      else if (WB_EN && (WB_ADR == AW'(r)) && !(issue && (dst_w == AW'(r))) && (pend_q[r] != '0))
        pend_d[r] = pend_q[r] - PEND_W'(1);
    end

    out_valid_d = out_valid_q;
    rdata1_d    = rdata1_q;
    rdata2_d    = rdata2_q;
    ed32_d      = ed32_q;
    dst_d       = dst_q;
    op_d        = op_q;
    funct_d     = funct_q;
    shamt_d     = shamt_q;
    if (issue) begin
      out_valid_d = 1'b1;
      rdata1_d    = rd1_w;
      rdata2_d    = rd2_w;
      ed32_d      = ed_w;
      dst_d       = dst_w;
      op_d        = op_w;
      funct_d     = INS[5:0];
      shamt_d     = INS[10:6];
    end else if (OUT_READY) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r]  <= '0;
        pend_q[r] <= '0;
      end
      out_valid_q <= 1'b0;
      rdata1_q    <= '0;
      rdata2_q    <= '0;
      ed32_q      <= '0;
      dst_q       <= '0;
      op_q        <= '0;
      funct_q     <= '0;
      shamt_q     <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        reg_q[r]  <= reg_d[r];
        pend_q[r] <= pend_d[r];
      end
      out_valid_q <= out_valid_d;
      rdata1_q    <= rdata1_d;
      rdata2_q    <= rdata2_d;
      ed32_q      <= ed32_d;
      dst_q       <= dst_d;
      op_q        <= op_d;
      funct_q     <= funct_d;
      shamt_q     <= shamt_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign RDATA1    = rdata1_q;
  assign RDATA2    = rdata2_q;
  assign ED32      = ed32_q;
  assign DST       = dst_q;
  assign OP        = op_q;
  assign FUNCT     = funct_q;
  assign SHAMT     = shamt_q;

endmodule

// File: tb/tb_id_stage_sb.sv
// Bench for id_stage_sb: directed instructions, expected bundles queued at issue
// and checked by an independent output monitor.
module tb_id_stage_sb;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] INS;
  logic        WB_EN;
  logic [4:0]  WB_ADR;
  logic [31:0] WB_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] RDATA1, RDATA2, ED32;
  logic [4:0]  DST;
  logic [5:0]  OP, FUNCT;
  logic [4:0]  SHAMT;
  logic        HAZARD;

  // BYPASS=0 copy, only used for the write-then-read check
  logic        d0_in_ready, d0_out_valid, d0_hazard;
  logic [31:0] d0_rdata1, d0_rdata2, d0_ed32;
  logic [4:0]  d0_dst, d0_shamt;
  logic [5:0]  d0_op, d0_funct;

  id_stage_sb #(.XLEN(32), .NREG(32), .PEND_W(2), .BYPASS(1)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .INS(INS),
    .WB_EN(WB_EN), .WB_ADR(WB_ADR), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .RDATA1(RDATA1), .RDATA2(RDATA2), .ED32(ED32), .DST(DST),
    .OP(OP), .FUNCT(FUNCT), .SHAMT(SHAMT), .HAZARD(HAZARD));

  id_stage_sb #(.XLEN(32), .NREG(32), .PEND_W(2), .BYPASS(0)) dut0 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(d0_in_ready), .INS(INS),
    .WB_EN(WB_EN), .WB_ADR(WB_ADR), .WB_DATA(WB_DATA),
    .OUT_VALID(d0_out_valid), .OUT_READY(1'b1),
    .RDATA1(d0_rdata1), .RDATA2(d0_rdata2), .ED32(d0_ed32), .DST(d0_dst),
    .OP(d0_op), .FUNCT(d0_funct), .SHAMT(d0_shamt), .HAZARD(d0_hazard));

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] r1, r2, ed;
    logic [4:0]  dst;
    logic [5:0]  op, funct;
    logic [4:0]  shamt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic exp_t mk(logic [31:0] r1, logic [31:0] r2, logic [31:0] ed,
                              logic [4:0] dst, logic [5:0] op, logic [5:0] funct,
                              logic [4:0] shamt);
    exp_t e;
    e.r1 = r1; e.r2 = r2; e.ed = ed; e.dst = dst;
    e.op = op; e.funct = funct; e.shamt = shamt;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented bundle must match the oldest expected one; pop on accept.
  always @(negedge CLK) begin
    if (RST === 1'b1 && OUT_VALID === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_bundle: OUT_VALID=1 with nothing expected (t=%0t)", $time);
      end else begin
        chk("rdata1", RDATA1, exp_q[0].r1);
        chk("rdata2", RDATA2, exp_q[0].r2);
        chk("ed32",   ED32,   exp_q[0].ed);
        chk("dst",    32'(DST),   32'(exp_q[0].dst));
        chk("op",     32'(OP),    32'(exp_q[0].op));
        chk("funct",  32'(FUNCT), 32'(exp_q[0].funct));
        chk("shamt",  32'(SHAMT), 32'(exp_q[0].shamt));
        if (OUT_READY) void'(exp_q.pop_front());
      end
    end
  end

  // INS/IN_VALID already driven; waits (bounded) for IN_READY, then records the issue.
  task automatic wait_issue(input exp_t e, output int waited);
    waited = 0;
    forever begin
      @(negedge CLK);
      if (IN_READY) break;
      waited++;
      if (waited >= 20) begin
        n_cmp++;
        n_err++;
        $display("FAIL issue_timeout: INS=0x%08h never accepted, want accepted", INS);
        IN_VALID = 1'b0;
        return;
      end
    end
    @(posedge CLK);
    exp_q.push_back(e);
    #1;
    IN_VALID = 1'b0;
  endtask

  task automatic present(input logic [31:0] ins);
    INS      = ins;
    IN_VALID = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  int w;

  initial begin
    RST = 1'b0; IN_VALID = 1'b0; INS = '0; WB_EN = 1'b0; WB_ADR = '0; WB_DATA = '0;
    OUT_READY = 1'b1;
    idle(2);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_rdata1",    RDATA1, 32'd0);
    chk("rst_rdata2",    RDATA2, 32'd0);
    chk("rst_ed32",      ED32,   32'd0);
    chk("rst_dst",       32'(DST), 32'd0);
    chk("rst_op",        32'(OP),  32'd0);
    chk("rst_in_ready",  32'(IN_READY), 32'd1);
    chk("rst_hazard",    32'(HAZARD),   32'd0);
    idle(1);

    // addu $10,$9,$0 with WB $9=17 in the same cycle
    present(32'h01205021);
    WB_EN = 1'b1; WB_ADR = 5'd9; WB_DATA = 32'd17;
    wait_issue(mk(32'd17, 32'd0, 32'h00005021, 5'd10, 6'h00, 6'h21, 5'd0), w);
    WB_EN = 1'b0;
    chk("bypass_wait", 32'(w), 32'd0);
    @(negedge CLK);
    chk("nobypass_valid",  32'(d0_out_valid), 32'd1);
    chk("nobypass_rdata1", d0_rdata1, 32'd0);
    idle(1);

    // addiu $8,$0,-1 then dependent ori $9,$8,0xFFFF
    present(32'h2408FFFF);
    wait_issue(mk(32'd0, 32'd0, 32'hFFFFFFFF, 5'd8, 6'h09, 6'h3F, 5'd31), w);
    present(32'h3509FFFF);
    repeat (2) begin
      @(negedge CLK);
      chk("ori_hazard",   32'(HAZARD),   32'd1);
      chk("ori_in_ready", 32'(IN_READY), 32'd0);
    end
    @(posedge CLK); #1;
    WB_EN = 1'b1; WB_ADR = 5'd8; WB_DATA = 32'h12345678;
    wait_issue(mk(32'h12345678, 32'd17, 32'h0000FFFF, 5'd9, 6'h0D, 6'h3F, 5'd31), w);
    WB_EN = 1'b0;
    chk("ori_wb_wait", 32'(w), 32'd0);
    idle(2);

    // back-pressure
    OUT_READY = 1'b0;
    present(32'h24030005);
    wait_issue(mk(32'd0, 32'd0, 32'd5, 5'd3, 6'h09, 6'h05, 5'd0), w);
    present(32'h24040006);
    repeat (3) begin
      @(negedge CLK);
      chk("bp_in_ready", 32'(IN_READY), 32'd0);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    wait_issue(mk(32'd0, 32'd0, 32'd6, 5'd4, 6'h09, 6'h06, 5'd0), w);
    chk("bp_release_wait", 32'(w), 32'd0);
    idle(2);

    // three writers of $5 saturate pend[5]; the fourth waits for one WB
    present(32'h24050001);
    wait_issue(mk(32'd0, 32'd0, 32'd1, 5'd5, 6'h09, 6'h01, 5'd0), w);
    present(32'h24050002);
    wait_issue(mk(32'd0, 32'd0, 32'd2, 5'd5, 6'h09, 6'h02, 5'd0), w);
    present(32'h24050003);
    wait_issue(mk(32'd0, 32'd0, 32'd3, 5'd5, 6'h09, 6'h03, 5'd0), w);
    present(32'h24050004);
    repeat (2) begin
      @(negedge CLK);
      chk("sat_hazard", 32'(HAZARD), 32'd1);
    end
    @(posedge CLK); #1;
    WB_EN = 1'b1; WB_ADR = 5'd5; WB_DATA = 32'h55;
    @(negedge CLK);
    chk("sat_hazard_during_wb", 32'(HAZARD), 32'd1);
    @(posedge CLK); #1;
    WB_EN = 1'b0;
    wait_issue(mk(32'd0, 32'h55, 32'd4, 5'd5, 6'h09, 6'h04, 5'd0), w);
    chk("sat_after_wb_wait", 32'(w), 32'd0);

    // JAL: no source use even when rs field names a busy register
    present(32'h0C000010);
    wait_issue(mk(32'd0, 32'd0, 32'h10, 5'd31, 6'h03, 6'h10, 5'd0), w);
    chk("jal_wait", 32'(w), 32'd0);
    present(32'h0CA00010);
    wait_issue(mk(32'h55, 32'd0, 32'h10, 5'd31, 6'h03, 6'h10, 5'd0), w);
    chk("jal_busy_rs_wait", 32'(w), 32'd0);

    // sw $9,4($0): rt source busy from ori, released by WB with bypass; no dest
    present(32'hAC090004);
    @(negedge CLK);
    chk("sw_hazard", 32'(HAZARD), 32'd1);
    @(posedge CLK); #1;
    WB_EN = 1'b1; WB_ADR = 5'd9; WB_DATA = 32'h99;
    wait_issue(mk(32'd0, 32'h99, 32'd4, 5'd0, 6'h2B, 6'h04, 5'd0), w);
    WB_EN = 1'b0;
    chk("sw_wb_wait", 32'(w), 32'd0);

    // write to $0 alongside a read of $0
    present(32'h00000821);
    WB_EN = 1'b1; WB_ADR = 5'd0; WB_DATA = 32'hDEAD;
    wait_issue(mk(32'd0, 32'd0, 32'h821, 5'd1, 6'h00, 6'h21, 5'd0), w);
    WB_EN = 1'b0;
    present(32'h00001021);
    wait_issue(mk(32'd0, 32'd0, 32'h1021, 5'd2, 6'h00, 6'h21, 5'd0), w);

    idle(4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
